// File: rtl/tmds_pkg.sv
// TMDS link controller shared definitions:
// control symbols, FSM state encoding and test pattern.
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] PATTERN_CLK = 10'b0000011111;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    RESET_HOLD = 2'd1,
    SETTLE     = 2'd2,
    RUN        = 2'd3
  } state_t;

endpackage

// File: rtl/tmds_link_ctrl_sync.sv
// Two-flop synchronizer for asynchronous level inputs,
// synchronous active-high reset clears both stages.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmds_link_ctrl.sv
// TMDS link bring-up: lock sync, OSERDES reset, preamble, run.
// Optional TMDS_LINK_CTRL_PATTERN_EN adds i_pattern clock pattern.
module tmds_link_ctrl
  import tmds_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
`ifdef TMDS_LINK_CTRL_PATTERN_EN
  input  logic       i_pattern,
`endif
  input  logic [9:0] i_tmds_ch0,
  input  logic [9:0] i_tmds_ch1,
  input  logic [9:0] i_tmds_ch2,
  output logic [9:0] o_tmds_ch0,
  output logic [9:0] o_tmds_ch1,
  output logic [9:0] o_tmds_ch2,
  output logic       o_rst_oserdes,
  output logic       o_ready,
  output logic [1:0] o_state
);

  if (RST_CYCLES == 0 || SETTLE_CYCLES == 0) begin : g_bad_cfg
    $error("RST_CYCLES and SETTLE_CYCLES must be nonzero");
  end

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  logic        lock_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  sel0, sel1, sel2;
  logic        run_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_pll_locked),
    .q   (lock_s)
  );

  // Counter restarts on every state entry so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = RESET_HOLD;
      end
      RESET_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: cnt_d = '0;
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  assign run_d = (state_d == RUN);

`ifdef TMDS_LINK_CTRL_PATTERN_EN
  assign sel0 = i_pattern ? PATTERN_CLK : i_tmds_ch0;
  assign sel1 = i_pattern ? PATTERN_CLK : i_tmds_ch1;
  assign sel2 = i_pattern ? PATTERN_CLK : i_tmds_ch2;
`else
  assign sel0 = i_tmds_ch0;
  assign sel1 = i_tmds_ch1;
  assign sel2 = i_tmds_ch2;
`endif

  // Outputs register the next state so they line up with state_q
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      o_rst_oserdes <= 1'b1;
      o_ready       <= 1'b0;
      o_tmds_ch0    <= CTRL_00;
      o_tmds_ch1    <= CTRL_00;
      o_tmds_ch2    <= CTRL_00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_rst_oserdes <= (state_d == WAIT_LOCK) ||
                       (state_d == RESET_HOLD);
      o_ready       <= run_d;
      o_tmds_ch0    <= run_d ? sel0 : CTRL_00;
      o_tmds_ch1    <= run_d ? sel1 : CTRL_00;
      o_tmds_ch2    <= run_d ? sel2 : CTRL_00;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Directed self-checking bench for tmds_link_ctrl
// with RST_CYCLES=4, SETTLE_CYCLES=16.
module tb_tmds_link_ctrl;
  import tmds_pkg::*;

  localparam int RST_C = 4;
  localparam int SET_C = 16;
  localparam int T_RST = 2 + RST_C;
  localparam int T_RDY = 2 + RST_C + SET_C;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       pat;
  logic [9:0] in0, in1, in2;
  logic [9:0] o0, o1, o2;
  logic       orst, ordy;
  logic [1:0] ost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_link_ctrl #(
    .RST_CYCLES    (RST_C),
    .SETTLE_CYCLES (SET_C)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pll_locked  (lock),
`ifdef TMDS_LINK_CTRL_PATTERN_EN
    .i_pattern     (pat),
`endif
    .i_tmds_ch0    (in0),
    .i_tmds_ch1    (in1),
    .i_tmds_ch2    (in2),
    .o_tmds_ch0    (o0),
    .o_tmds_ch1    (o1),
    .o_tmds_ch2    (o2),
    .o_rst_oserdes (orst),
    .o_ready       (ordy),
    .o_state       (ost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_run(input logic [9:0] d);
    return pat ? PATTERN_CLK : d;
  endfunction

  // n counts edges from E0 (first edge sampling lock=1)
  task automatic check_seq(input int first_n, input int last_n);
    for (int n = first_n; n <= last_n; n++) begin
      logic [1:0] es;
      logic       er, ey;
      logic [9:0] e0, e1, e2;
      tick();
      es = (n < 2) ? 2'd0 : (n < T_RST) ? 2'd1 :
           (n < T_RDY) ? 2'd2 : 2'd3;
      er = (n < T_RST);
      ey = (n >= T_RDY);
      e0 = ey ? exp_run(in0) : CTRL_00;
      e1 = ey ? exp_run(in1) : CTRL_00;
      e2 = ey ? exp_run(in2) : CTRL_00;
      checks++;
      if (ost !== es) begin
        errors++;
        $display("FAIL seq_state n=%0d got %0d exp %0d", n, ost, es);
      end
      checks++;
      if (orst !== er) begin
        errors++;
        $display("FAIL seq_rst n=%0d got %b exp %b", n, orst, er);
      end
      checks++;
      if (ordy !== ey) begin
        errors++;
        $display("FAIL seq_ready n=%0d got %b exp %b", n, ordy, ey);
      end
      checks++;
      if ({o0, o1, o2} !== {e0, e1, e2}) begin
        errors++;
        $display("FAIL seq_tmds n=%0d got %h %h %h exp %h %h %h",
                 n, o0, o1, o2, e0, e1, e2);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({ost, orst, ordy} !== {2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s ctrl got st=%0d rst=%b rdy=%b exp 0 1 0",
               name, ost, orst, ordy);
    end
    checks++;
    if ({o0, o1, o2} !== {CTRL_00, CTRL_00, CTRL_00}) begin
      errors++;
      $display("FAIL %s tmds got %h %h %h exp %h",
               name, o0, o1, o2, CTRL_00);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    lock = 1'b1;
    pat  = 1'b0;
    in0  = 10'h123;
    in1  = 10'h0F0;
    in2  = 10'h30C;
    tick();
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
  endtask

  task automatic test_startup();
    check_seq(0, 25);
  endtask

  task automatic test_data();
    logic [9:0] vec [3][3];
    logic [9:0] p0, p1, p2;
    vec[0] = '{10'h2AA, 10'h155, 10'h3F0};
    vec[1] = '{10'h3FF, 10'h000, 10'h1E1};
    vec[2] = '{10'h001, 10'h200, 10'h0AA};
    for (int i = 0; i < 3; i++) begin
      p0  = in0;
      p1  = in1;
      p2  = in2;
      in0 = vec[i][0];
      in1 = vec[i][1];
      in2 = vec[i][2];
      checks++;
      if ({o0, o1, o2} !== {p0, p1, p2}) begin
        errors++;
        $display("FAIL data_hold%0d got %h %h %h exp %h %h %h",
                 i, o0, o1, o2, p0, p1, p2);
      end
      tick();
      checks++;
      if ({o0, o1, o2} !== {vec[i][0], vec[i][1], vec[i][2]}) begin
        errors++;
        $display("FAIL data%0d got %h %h %h exp %h %h %h", i,
                 o0, o1, o2, vec[i][0], vec[i][1], vec[i][2]);
      end
    end
  endtask

  task automatic test_lock_drop();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    checks++;
    if ({ost, ordy} !== {2'd3, 1'b1}) begin
      errors++;
      $display("FAIL drop_e1 got st=%0d rdy=%b exp 3 1", ost, ordy);
    end
    tick();
    checks++;
    if ({ost, ordy} !== {2'd3, 1'b1}) begin
      errors++;
      $display("FAIL drop_e2 got st=%0d rdy=%b exp 3 1", ost, ordy);
    end
    tick();
    check_idle("drop_e3");
    check_seq(2, 25);
  endtask

  task automatic test_settle_drop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_seq(0, 19);
    lock = 1'b0;
    check_seq(20, 20);
    lock = 1'b1;
    check_seq(21, 21);
    tick();
    check_idle("settle_drop");
    check_seq(2, 25);
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid_run");
    check_seq(0, 25);
  endtask

`ifdef TMDS_LINK_CTRL_PATTERN_EN
  task automatic test_pattern();
    pat = 1'b1;
    tick();
    checks++;
    if ({o0, o1, o2} !== {PATTERN_CLK, PATTERN_CLK, PATTERN_CLK}) begin
      errors++;
      $display("FAIL pattern_run got %h %h %h exp %h",
               o0, o1, o2, PATTERN_CLK);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("pattern_reset");
    check_seq(0, 25);
    pat = 1'b0;
    tick();
    checks++;
    if ({o0, o1, o2} !== {in0, in1, in2}) begin
      errors++;
      $display("FAIL pattern_off got %h %h %h exp %h %h %h",
               o0, o1, o2, in0, in1, in2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_data();
    test_lock_drop();
    test_settle_drop();
    test_reset_mid_run();
`ifdef TMDS_LINK_CTRL_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_link_ctrl.md
TMDS_LINK_CTRL -- requirements
Module: tmds_link_ctrl

Interface
- REQ-001: Parameter RST_CYCLES, default 8: number of i_clk cycles the OSERDES reset is held after lock; legal range 1..255.
- REQ-002: Parameter SETTLE_CYCLES, default 1024: number of i_clk cycles of control-symbol preamble after the reset is released; legal range 1..65535.
- REQ-003: Port i_clk, input, 1 bit: parallel (pixel) clock; the only clock in the block.
- REQ-004: Port i_rst, input, 1 bit: reset, synchronous to i_clk, active-high.
- REQ-005: Port i_pll_locked, input, 1 bit: MMCM lock indication, asynchronous to i_clk.
- REQ-006: Ports i_tmds_ch0, i_tmds_ch1, i_tmds_ch2, input, 10 bits each: encoded TMDS symbols from the encoders.
- REQ-007: Ports o_tmds_ch0, o_tmds_ch1, o_tmds_ch2, output, 10 bits each: symbols to the three serializers.
- REQ-008: Port o_rst_oserdes, output, 1 bit: active-high reset to all serializers.
- REQ-009: Port o_ready, output, 1 bit: the link is in RUN and passing video.
- REQ-010: Port o_state, output, 2 bits: current FSM state encoding, for debug.

Function
- REQ-011: i_pll_locked SHALL pass through a 2-flop synchronizer; lock_s is the second flop's output.
- REQ-012: The FSM SHALL have four states, encoded WAIT_LOCK=0, RESET_HOLD=1, SETTLE=2 and RUN=3.
- REQ-013: In WAIT_LOCK, a clock edge with lock_s=1 SHALL move the FSM to RESET_HOLD and clear the counter.
- REQ-014: RESET_HOLD SHALL last exactly RST_CYCLES cycles, then move to SETTLE and clear the counter.
- REQ-015: SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to RUN.
- REQ-016: RUN SHALL persist while lock_s=1.
- REQ-017: In any state, lock_s=0 SHALL force WAIT_LOCK at the next edge and clear the counter; this takes priority over every other transition, including a counter expiring on the same edge.
- REQ-018: o_rst_oserdes SHALL be 1 exactly when the state is WAIT_LOCK or RESET_HOLD; it is registered and free of glitches.
- REQ-019: Outside RUN, every o_tmds_chN SHALL equal CTRL_00 (10'b1101010100).
- REQ-020: In RUN, o_tmds_chN SHALL equal i_tmds_chN registered, giving 1-cycle latency.
- REQ-021: o_ready SHALL be 1 exactly when the state is RUN.
- REQ-022: Timing from the edge E0 that first samples i_pll_locked=1:
  - o_rst_oserdes falls after edge E0+2+RST_CYCLES;
  - o_ready rises after edge E0+2+RST_CYCLES+SETTLE_CYCLES.
- REQ-023: There is a single shared counter, 16 bits wide; it SHALL never wrap, because the counter is cleared on every state entry.

Reset
- REQ-024: While i_rst=1 at an edge, the block SHALL produce:
  - state=WAIT_LOCK and counter=0;
  - o_rst_oserdes=1 and o_ready=0;
  - all o_tmds_chN=CTRL_00;
  - synchronizer flops=0.
- REQ-025: Reset asserted mid-RUN SHALL take effect at the next edge, and the full WAIT_LOCK→RUN sequence SHALL then replay.

Configuration
- REQ-026: Macro TMDS_LINK_CTRL_PATTERN_EN defined: the block adds input i_pattern (1 bit). In RUN with i_pattern=1, every o_tmds_chN SHALL be 10'b0000011111 (clock-like pattern for scope/alignment), registered with the same 1-cycle latency.
- REQ-027: Macro TMDS_LINK_CTRL_PATTERN_EN undefined: the i_pattern port is absent and the RUN output is always pass-through.

Structure
- REQ-028: Shared package tmds_pkg SHALL hold:
  - the CTRL_00..CTRL_11 symbol constants;
  - the state enum typedef;
  - the PATTERN_CLK constant.
- REQ-029: Sub-module sync_2ff (parameterised width, default 1) SHALL implement the lock synchronizer.
- REQ-030: An elaboration-time check SHALL reject RST_CYCLES or SETTLE_CYCLES equal to 0.

Verification
- REQ-031: Run with RST_CYCLES=4, SETTLE_CYCLES=16 and i_pll_locked rising at E0 → o_rst_oserdes falls after E0+6, o_ready rises after E0+22, and o_tmds stays CTRL_00 until then.
- REQ-032: In RUN, drive ch0=10'h2AA, ch1=10'h155, ch2=10'h3F0 → the same values appear on the outputs one cycle later.
- REQ-033: Drop i_pll_locked for 1 cycle in RUN → within 3 edges: o_ready=0, o_rst_oserdes=1, outputs CTRL_00; then the full sequence replays after relock.
- REQ-034: Drop lock on the edge where the SETTLE counter expires → the FSM goes to WAIT_LOCK, not RUN.
- REQ-035: Pulse i_rst for 1 cycle mid-RUN → reset values hold the next cycle, and the sequence restarts with identical timing.
- REQ-036: With TMDS_LINK_CTRL_PATTERN_EN defined, i_pattern=1 in RUN → all channels carry 10'b0000011111; i_pattern=1 outside RUN → CTRL_00.
